// File: rtl/output_mem.sv
// Egress block buffer: collects B/G/R pixels from the rotate core, then
// drains them as little-endian 32-bit words to the AHB write master.
module output_mem #(
   parameter int BUF_PIXELS = 64
) (
   input  logic        I_OMEM_HCLK,
   input  logic        I_OMEM_HRESET_N,
   input  logic        I_OMEM_START,
   input  logic [6:0]  I_OMEM_PIXEL_COUNT,
   input  logic        I_OMEM_PIXEL_WRITE,
   input  logic [7:0]  I_OMEM_PIXEL_B,
   input  logic [7:0]  I_OMEM_PIXEL_G,
   input  logic [7:0]  I_OMEM_PIXEL_R,
   input  logic        I_OMEM_FLUSH,
   output logic        O_OMEM_FULL,
   output logic [31:0] O_OMEM_WDATA,
   output logic        O_OMEM_WVALID,
   input  logic        I_OMEM_WREADY,
   output logic        O_OMEM_DONE,
   output logic        O_OMEM_BUSY
);

   localparam int BUF_BYTES = 3 * BUF_PIXELS;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_e;

   state_e      state_q, state_d;
   logic [6:0]  n_q, n_d;
   logic [6:0]  wr_ptr_q, wr_ptr_d;
   logic [5:0]  rd_ptr_q, rd_ptr_d;
   logic        done_q, done_d;
   logic [7:0]  buf_q [BUF_BYTES];

   logic        clr_buf, wr_en;
   logic [6:0]  cnt_clamp;
   logic [8:0]  data_bytes;     // 3*wr_ptr: bytes holding pixel data
   logic [8:0]  next_word_byte; // first byte address after the current word
   logic [7:0]  waddr, raddr;
   logic        last_word;

   assign cnt_clamp      = (I_OMEM_PIXEL_COUNT > 7'(BUF_PIXELS)) ? 7'(BUF_PIXELS)
                                                                 : I_OMEM_PIXEL_COUNT;
   assign data_bytes     = {2'b00, wr_ptr_q} + {1'b0, wr_ptr_q, 1'b0};
   assign next_word_byte = {1'b0, rd_ptr_q, 2'b00} + 9'd4;
   // Word k is the last one once it reaches past the final data byte;
   // equivalent to k == ((3P+3)>>2)-1.
   assign last_word      = (next_word_byte >= data_bytes);
   assign waddr          = data_bytes[7:0];
   assign raddr          = {rd_ptr_q, 2'b00};

   // State, pointers and the done pulse
   always_ff @(posedge I_OMEM_HCLK or negedge I_OMEM_HRESET_N) begin
      if (!I_OMEM_HRESET_N) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic: fill until N pixels or flush, then drain W words
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      done_d   = 1'b0;
      clr_buf  = 1'b0;
      wr_en    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (I_OMEM_START) begin
               if (cnt_clamp == 7'd0) begin
                  done_d = 1'b1;
               end else begin
                  n_d      = cnt_clamp;
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
                  clr_buf  = 1'b1;
                  state_d  = S_FILL;
               end
            end
         end
         S_FILL: begin
            // wr_ptr < N <= BUF_PIXELS here, so the increment saturates naturally
            if (I_OMEM_PIXEL_WRITE && (wr_ptr_q < n_q)) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 7'd1;
            end
            if ((wr_en && (wr_ptr_d == n_q)) || I_OMEM_FLUSH) begin
               if (!wr_en && (wr_ptr_q == 7'd0)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = S_DRAIN;
                  rd_ptr_d = '0;
               end
            end
         end
         S_DRAIN: begin
            if (I_OMEM_WREADY) begin
               if (last_word) begin
                  state_d  = S_IDLE;
                  done_d   = 1'b1;
                  rd_ptr_d = '0;
               end else begin
                  rd_ptr_d = rd_ptr_q + 6'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Byte buffer: cleared at block start so padding bytes read as zero
   always_ff @(posedge I_OMEM_HCLK or negedge I_OMEM_HRESET_N) begin
      if (!I_OMEM_HRESET_N) begin
         for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
      end else if (clr_buf) begin
         for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
      end else if (wr_en) begin
         buf_q[waddr]        <= I_OMEM_PIXEL_B;
         buf_q[waddr + 8'd1] <= I_OMEM_PIXEL_G;
         buf_q[waddr + 8'd2] <= I_OMEM_PIXEL_R;
      end
   end

   // Outputs decode from registered state only, so reset clears them at once
   always_comb begin
      O_OMEM_WVALID = (state_q == S_DRAIN);
      O_OMEM_FULL   = (state_q == S_DRAIN);
      O_OMEM_BUSY   = (state_q != S_IDLE);
      O_OMEM_DONE   = done_q;
      O_OMEM_WDATA  = '0;
      if (state_q == S_DRAIN)
         O_OMEM_WDATA = {buf_q[raddr + 8'd3], buf_q[raddr + 8'd2],
                         buf_q[raddr + 8'd1], buf_q[raddr]};
   end

endmodule

// File: tb/tb_output_mem.sv
// Directed bench for output_mem: table of block transfers plus hand-written
// reset, stall and back-to-back START sequences.
module tb_output_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, pw = 1'b0, flush = 1'b0, wready = 1'b0;
   logic [6:0]  cnt = '0;
   logic [7:0]  pb = '0, pg = '0, pr = '0;
   logic        full, wvalid, done, busy;
   logic [31:0] wdata;

   int nvec = 0;
   int nerr = 0;

   output_mem dut (
      .I_OMEM_HCLK        (clk),
      .I_OMEM_HRESET_N    (rst_n),
      .I_OMEM_START       (start),
      .I_OMEM_PIXEL_COUNT (cnt),
      .I_OMEM_PIXEL_WRITE (pw),
      .I_OMEM_PIXEL_B     (pb),
      .I_OMEM_PIXEL_G     (pg),
      .I_OMEM_PIXEL_R     (pr),
      .I_OMEM_FLUSH       (flush),
      .O_OMEM_FULL        (full),
      .O_OMEM_WDATA       (wdata),
      .O_OMEM_WVALID      (wvalid),
      .I_OMEM_WREADY      (wready),
      .O_OMEM_DONE        (done),
      .O_OMEM_BUSY        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          count;     // PIXEL_COUNT driven with START
      int          npix;      // pixels actually written
      int          flush;     // FLUSH after the pixels
      int          pat;       // 0: byte i = i+1, 1: AA/BB/CC, 2: (n, n+64, n+128)
      int          stall_at;  // word index to hold WREADY low on (-1 none)
      int          stall_len;
      int          junk;      // pulse PIXEL_WRITE during drain
      int          nw;        // expected word count
      logic [31:0] w0;        // expected first word
      logic [31:0] wl;        // expected last word
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int pat, input int npix, input int idx);
      int pix, c;
      if (idx >= 3 * npix) return 8'h00;
      pix = idx / 3;
      c   = idx % 3;
      case (pat)
         0:       return 8'(idx + 1);
         1:       return (c == 0) ? 8'hAA : (c == 1) ? 8'hBB : 8'hCC;
         default: return 8'(pix + 64 * c);
      endcase
   endfunction

   function automatic logic [31:0] exp_word(input int pat, input int npix, input int k);
      return {exp_byte(pat, npix, 4*k+3), exp_byte(pat, npix, 4*k+2),
              exp_byte(pat, npix, 4*k+1), exp_byte(pat, npix, 4*k)};
   endfunction

   task automatic set_pixel(input int pat, input int n);
      case (pat)
         0:       begin pb = 8'(3*n+1); pg = 8'(3*n+2); pr = 8'(3*n+3); end
         1:       begin pb = 8'hAA; pg = 8'hBB; pr = 8'hCC; end
         default: begin pb = 8'(n); pg = 8'(n+64); pr = 8'(n+128); end
      endcase
   endtask

   task automatic run_vec(input vec_t v);
      int hs = 0;
      int stall = 0;
      int budget = 0;
      @(negedge clk);
      start = 1'b1; cnt = 7'(v.count);
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < v.npix; p++) begin
         set_pixel(v.pat, p); pw = 1'b1;
         @(negedge clk);
      end
      pw = 1'b0;
      if (v.flush != 0) begin
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
      end
      if (v.nw > 0) chk("first_valid", 32'(wvalid), 32'd1);
      while (hs < v.nw && budget < 400) begin
         chk("wvalid", 32'(wvalid), 32'd1);
         chk("wdata", wdata, exp_word(v.pat, v.npix, hs));
         if (hs == 0) chk("word0", wdata, v.w0);
         if (hs == v.nw - 1) chk("word_last", wdata, v.wl);
         if (v.junk != 0) begin
            chk("full", 32'(full), 32'd1);
            pw = 1'b1; pb = 8'($urandom); pg = 8'($urandom); pr = 8'($urandom);
         end
         if (hs == v.stall_at && stall < v.stall_len) begin
            wready = 1'b0; stall++;
         end else begin
            wready = 1'b1;
         end
         if (wready) hs++;
         @(negedge clk);
         budget++;
      end
      pw = 1'b0; wready = 1'b0;
      if (budget >= 400) begin
         nvec++; nerr++;
         $display("FAIL drain_timeout: got %0d words expected %0d", hs, v.nw);
      end
      chk("handshakes", 32'(hs), 32'(v.nw));
      chk("done_pulse", 32'(done), 32'd1);
      chk("wvalid_after", 32'(wvalid), 32'd0);
      chk("wdata_idle", wdata, 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_once", 32'(done), 32'd0);
   endtask

   initial begin
      vt[0] = '{4,   4,  0, 0, -1, 0, 0, 3,  32'h04030201, 32'h0C0B0A09};
      vt[1] = '{1,   1,  0, 1, -1, 0, 0, 1,  32'h00CCBBAA, 32'h00CCBBAA};
      vt[2] = '{4,   4,  0, 0,  1, 5, 0, 3,  32'h04030201, 32'h0C0B0A09};
      vt[3] = '{64,  2,  1, 0, -1, 0, 1, 2,  32'h04030201, 32'h00000605};
      vt[4] = '{64,  64, 0, 2, -1, 0, 0, 48, 32'h01804000, 32'hBF7F3FBE};
      vt[5] = '{100, 64, 0, 2, -1, 0, 0, 48, 32'h01804000, 32'hBF7F3FBE};
      vt[6] = '{0,   0,  0, 0, -1, 0, 0, 0,  32'h0,        32'h0};
      vt[7] = '{5,   5,  0, 0, -1, 0, 0, 4,  32'h04030201, 32'h000F0E0D};
      vt[8] = '{10,  0,  1, 0, -1, 0, 0, 0,  32'h0,        32'h0};

      // reset state
      #12;
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset asserted mid-drain with WREADY low
      @(negedge clk);
      start = 1'b1; cnt = 7'd4;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 4; p++) begin
         set_pixel(0, p); pw = 1'b1;
         @(negedge clk);
      end
      pw = 1'b0;
      chk("pre_rst_wvalid", 32'(wvalid), 32'd1);
      chk("pre_rst_full", 32'(full), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wvalid", 32'(wvalid), 32'd0);
      chk("arst_wdata", wdata, 32'd0);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 9; i++) run_vec(vt[i]);

      // START accepted in the same cycle DONE is high
      @(negedge clk);
      start = 1'b1; cnt = 7'd0;
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'd1);
      cnt = 7'd1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      set_pixel(1, 0); pw = 1'b1;
      @(negedge clk);
      pw = 1'b0;
      chk("b2b_wvalid", 32'(wvalid), 32'd1);
      chk("b2b_wdata", wdata, 32'h00CCBBAA);
      wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
      chk("b2b_end_done", 32'(done), 32'd1);
      chk("b2b_end_wvalid", 32'(wvalid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
